register_write_arbiter: RTL and testbench

REGISTER_WRITE_ARBITER -- requirements
Module: register_write_arbiter

---
 rtl/register_write_arbiter_pkg.sv | 6 +
 rtl/register_write_arbiter_rr_select.sv | 29 ++
 rtl/register_write_arbiter.sv | 113 +++++++++++
 tb/tb_register_write_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/register_write_arbiter_pkg.sv
// Constants shared between the write arbiter and the register bank it feeds.
package register_write_arbiter_pkg;
  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 4;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;
endpackage

// File: rtl/register_write_arbiter_rr_select.sv
// Round-robin selector: one-hot grant of the first request found after ptr_i.
module rr_select #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic          valid_o
);

  int idx;

  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = 0;
    // ptr_i itself is visited last, so the previous winner has lowest priority.
    for (int i = 1; i <= N; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= N) idx = idx - N;
      if (!valid_o && req_i[idx[PW-1:0]]) begin
        grant_o[idx[PW-1:0]] = 1'b1;
        valid_o              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/register_write_arbiter.sv
// Per-requester single-entry holding slots, round-robin drained into one
// register-bank write port; writes to register 0 are swallowed on acceptance.
module register_write_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int DATA_WIDTH     = register_write_arbiter_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = register_write_arbiter_pkg::REG_ADDR_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic [NUM_REQ-1:0]                 reqValid,
  output logic [NUM_REQ-1:0]                 reqReady,
  input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]  reqRegNum,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      reqData,
  output logic [REG_ADDR_WIDTH-1:0]          wRegNum,
  output logic [DATA_WIDTH-1:0]              wDataIn,
  output logic                               writeEnable,
  output logic [2**REG_ADDR_WIDTH-1:0]       pendingMask
);
  import register_write_arbiter_pkg::*;

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [REG_ADDR_WIDTH-1:0] ZREG = REG_ADDR_WIDTH'(ZERO_REG);

  logic [NUM_REQ-1:0]        slot_valid_q;
  logic [REG_ADDR_WIDTH-1:0] slot_reg_q  [NUM_REQ];
  logic [DATA_WIDTH-1:0]     slot_data_q [NUM_REQ];
  logic [PW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]        grant;
  logic                      grant_valid;
  logic [NUM_REQ-1:0]        fire;
  logic                      write_en;

  rr_select #(.N(NUM_REQ), .PW(PW)) u_rr_select (
    .req_i   (slot_valid_q),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .valid_o (grant_valid)
  );

  assign write_en    = grant_valid & ~flush;
  assign writeEnable = write_en;
  // Gated by reset so nothing looks acceptable while the slots are held clear.
  assign reqReady    = {NUM_REQ{reset & ~flush}} & (~slot_valid_q | grant);
  assign fire        = reqValid & reqReady;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
    logic                      valid_q, valid_d;
    logic [REG_ADDR_WIDTH-1:0] reg_q, reg_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [REG_ADDR_WIDTH-1:0] in_reg;

    assign in_reg            = reqRegNum[gi*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    assign slot_valid_q[gi]  = valid_q;
    assign slot_reg_q[gi]    = reg_q;
    assign slot_data_q[gi]   = data_q;

    always_comb begin
      valid_d = valid_q;
      reg_d   = reg_q;
      data_d  = data_q;
      if (flush) begin
        valid_d = 1'b0;
      end else if (fire[gi]) begin
        valid_d = (in_reg != ZREG);
        reg_d   = in_reg;
        data_d  = reqData[gi*DATA_WIDTH +: DATA_WIDTH];
      end else if (grant[gi]) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        valid_q <= 1'b0;
        reg_q   <= '0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        reg_q   <= reg_d;
        data_q  <= data_d;
      end
    end
  end

  always_comb begin
    wRegNum  = '0;
    wDataIn  = '0;
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (write_en && grant[k]) begin
        wRegNum  = slot_reg_q[k];
        wDataIn  = slot_data_q[k];
        rr_ptr_d = PW'(k);
      end
    end
  end

  always_comb begin
    pendingMask = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (slot_valid_q[k]) pendingMask[slot_reg_q[k]] = 1'b1;
    end
    pendingMask[ZREG] = 1'b0;
  end

  // Reset pointer sits on the last requester so requester 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_ptr_q <= PW'(NUM_REQ - 1);
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed scoreboard bench: stimulus queues expected bank writes, a negedge
// monitor pops and compares each write the arbiter presents.
module tb_register_write_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            flush = 1'b0;
  logic [N-1:0]    reqValid = '0;
  logic [N-1:0]    reqReady;
  logic [N*AW-1:0] reqRegNum = '0;
  logic [N*DW-1:0] reqData = '0;
  logic [AW-1:0]   wRegNum;
  logic [DW-1:0]   wDataIn;
  logic            writeEnable;
  logic [15:0]     pendingMask;

  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } wr_t;

  wr_t          exp_q[$];
  logic [DW-1:0] bank [16];
  int checks = 0;
  int errors = 0;
  int idx0, idx2;
  logic [N-1:0] f;

  register_write_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .reqValid    (reqValid),
    .reqReady    (reqReady),
    .reqRegNum   (reqRegNum),
    .reqData     (reqData),
    .wRegNum     (wRegNum),
    .wDataIn     (wDataIn),
    .writeEnable (writeEnable),
    .pendingMask (pendingMask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] r, input logic [DW-1:0] d);
    wr_t w;
    w.r = r;
    w.d = d;
    exp_q.push_back(w);
  endtask

  task automatic drive(input int k, input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
    reqValid[k]         = v;
    reqRegNum[k*AW +: AW] = r;
    reqData[k*DW +: DW]   = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bank model commits on the rising edge, as the real register bank does.
  initial for (int i = 0; i < 16; i++) bank[i] = '0;
  always @(posedge clk) if (writeEnable) bank[wRegNum] <= wDataIn;

  always @(negedge clk) begin
    if (writeEnable) begin
      $display("write reg=%0d data=0x%08h", wRegNum, wDataIn);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got reg %0d data 0x%08h, required no write", wRegNum, wDataIn);
      end else begin
        check("write_reg", 64'(wRegNum), 64'(exp_q[0].r));
        check("write_data", 64'(wDataIn), 64'(exp_q[0].d));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_ready", 64'(reqReady), 64'h0);
    check("rst_we", 64'(writeEnable), 64'h0);
    check("rst_wreg", 64'(wRegNum), 64'h0);
    check("rst_wdata", 64'(wDataIn), 64'h0);
    check("rst_pending", 64'(pendingMask), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(reqReady), 64'h7);
    check("idle_we", 64'(writeEnable), 64'h0);
    check("idle_pending", 64'(pendingMask), 64'h0);

    // Three simultaneous writes drain in order 0,1,2
    tick();
    drive(0, 1'b1, 4'd1, 32'h11111111);
    drive(1, 1'b1, 4'd2, 32'h22222222);
    drive(2, 1'b1, 4'd3, 32'h33333333);
    push(4'd1, 32'h11111111);
    push(4'd2, 32'h22222222);
    push(4'd3, 32'h33333333);
    tick();
    reqValid = '0;
    @(negedge clk); check("pend_e", 64'(pendingMask), 64'h000E);
    @(negedge clk); check("pend_c", 64'(pendingMask), 64'h000C);
    @(negedge clk); check("pend_8", 64'(pendingMask), 64'h0008);
    @(negedge clk); check("pend_0", 64'(pendingMask), 64'h0000);
    check("t1_drained", 64'(exp_q.size()), 64'h0);

    // Requesters 0 and 2 continuously valid: grants alternate 0,2,0,2,...
    push(4'd4, 32'hA0000000);
    push(4'd12, 32'hC0000000);
    push(4'd5, 32'hA0000001);
    push(4'd13, 32'hC0000001);
    push(4'd6, 32'hA0000002);
    push(4'd14, 32'hC0000002);
    idx0 = 0;
    idx2 = 0;
    tick();
    drive(0, 1'b1, 4'd4, 32'hA0000000);
    drive(2, 1'b1, 4'd12, 32'hC0000000);
    for (int cyc = 0; cyc < 12 && (idx0 < 3 || idx2 < 3); cyc++) begin
      @(negedge clk);
      check("ready1_held", 64'(reqReady[1]), 64'h1);
      f = reqValid & reqReady;
      tick();
      if (f[0]) idx0++;
      if (f[2]) idx2++;
      drive(0, idx0 < 3, AW'(4 + idx0), 32'hA0000000 + idx0);
      drive(2, idx2 < 3, AW'(12 + idx2), 32'hC0000000 + idx2);
    end
    reqValid = '0;
    repeat (4) tick();
    check("t4_drained", 64'(exp_q.size()), 64'h0);

    // Requester 1 streams back-to-back at full rate
    push(4'd5, 32'h55555555);
    push(4'd6, 32'h66666666);
    push(4'd7, 32'h77777777);
    tick();
    drive(1, 1'b1, 4'd5, 32'h55555555);
    @(negedge clk); check("stream_we_pre", 64'(writeEnable), 64'h0);
    tick();
    drive(1, 1'b1, 4'd6, 32'h66666666);
    @(negedge clk); check("stream_ready_a", 64'(reqReady[1]), 64'h1);
    check("stream_we_a", 64'(writeEnable), 64'h1);
    tick();
    drive(1, 1'b1, 4'd7, 32'h77777777);
    @(negedge clk); check("stream_ready_b", 64'(reqReady[1]), 64'h1);
    check("stream_we_b", 64'(writeEnable), 64'h1);
    tick();
    reqValid = '0;
    @(negedge clk); check("stream_we_c", 64'(writeEnable), 64'h1);
    tick();
    @(negedge clk); check("stream_we_post", 64'(writeEnable), 64'h0);
    check("t2_drained", 64'(exp_q.size()), 64'h0);

    // Register 0 write is accepted and discarded
    tick();
    drive(0, 1'b1, 4'd0, 32'hFFFFFFFF);
    @(negedge clk); check("r0_ready", 64'(reqReady[0]), 64'h1);
    tick();
    reqValid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("r0_we", 64'(writeEnable), 64'h0);
      check("r0_pending", 64'(pendingMask), 64'h0);
    end
    check("r0_bank", 64'(bank[0]), 64'h0);

    // Fill all three slots, then flush
    tick();
    drive(0, 1'b1, 4'd1, 32'hDEAD0001);
    drive(1, 1'b1, 4'd2, 32'hDEAD0002);
    drive(2, 1'b1, 4'd3, 32'hDEAD0003);
    tick();
    reqValid = '0;
    flush = 1'b1;
    @(negedge clk);
    check("flush_we", 64'(writeEnable), 64'h0);
    check("flush_ready", 64'(reqReady), 64'h0);
    check("flush_pend_full", 64'(pendingMask), 64'h000E);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("post_flush_pend", 64'(pendingMask), 64'h0);
    check("post_flush_we", 64'(writeEnable), 64'h0);
    tick();
    check("flush_bank1", 64'(bank[1]), 64'h11111111);
    check("flush_bank2", 64'(bank[2]), 64'h22222222);
    check("flush_bank3", 64'(bank[3]), 64'h33333333);

    // Asynchronous reset mid-cycle with full slots
    tick();
    drive(0, 1'b1, 4'd1, 32'hBAD00001);
    drive(1, 1'b1, 4'd2, 32'hBAD00002);
    drive(2, 1'b1, 4'd3, 32'hBAD00003);
    tick();
    reqValid = '0;
    #2;
    reset = 1'b0;
    #1;
    check("arst_ready", 64'(reqReady), 64'h0);
    check("arst_we", 64'(writeEnable), 64'h0);
    check("arst_wreg", 64'(wRegNum), 64'h0);
    check("arst_wdata", 64'(wDataIn), 64'h0);
    check("arst_pending", 64'(pendingMask), 64'h0);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    tick();
    drive(2, 1'b1, 4'd11, 32'h0B0B0B0B);
    drive(0, 1'b1, 4'd10, 32'h0A0A0A0A);
    push(4'd10, 32'h0A0A0A0A);
    push(4'd11, 32'h0B0B0B0B);
    tick();
    reqValid = '0;
    repeat (4) tick();
    check("arst_drained", 64'(exp_q.size()), 64'h0);
    check("arst_bank1", 64'(bank[1]), 64'h11111111);
    check("arst_bank10", 64'(bank[10]), 64'h0A0A0A0A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
